// File: rtl/packet_assembler.sv
// Serialises one data island packet (header plus four subpackets) over 32 pixel
// clocks, appending a BCH ECC byte to each stream. The output is registered, so it lags the counter by one cycle.
module packet_assembler (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        data_island_period,
  input  logic [23:0] header,
  input  logic [55:0] sub [3:0],
  output logic        packet_enable,
  output logic [8:0]  packet_data
);

  logic [4:0]  c;
  logic [7:0]  eh;
  logic [7:0]  es [3:0];

  logic [31:0] header_ext;
  logic [63:0] sub_ext [3:0];
  logic [7:0]  eh_next;
  logic [7:0]  es_next [3:0];
  logic        hdr_bit;
  logic [3:0]  even_bits;
  logic [3:0]  odd_bits;

  function automatic logic [7:0] step(input logic [7:0] e, input logic b);
    logic f;
    f = e[0] ^ b;
    return {1'b0, e[7:1]} ^ (f ? 8'h83 : 8'h00);
  endfunction

  assign packet_enable = data_island_period && (c == 5'd31);

  // Inputs are padded to the full stream length so the counter can index them
  // directly; the padding positions are always replaced by ECC bits.
  always_comb begin
    header_ext = {8'h00, header};
    eh_next    = step((c == 5'd0) ? 8'h00 : eh, header_ext[c]);
    hdr_bit    = (c < 5'd24) ? header_ext[c] : eh[c[2:0]];
    even_bits  = '0;
    odd_bits   = '0;
    for (int i = 0; i < 4; i++) begin
      sub_ext[i] = {8'h00, sub[i]};
      es_next[i] = step(step((c == 5'd0) ? 8'h00 : es[i], sub_ext[i][{c, 1'b0}]),
                        sub_ext[i][{c, 1'b1}]);
      even_bits[i] = (c < 5'd28) ? sub_ext[i][{c, 1'b0}] : es[i][{c[1:0], 1'b0}];
      odd_bits[i]  = (c < 5'd28) ? sub_ext[i][{c, 1'b1}] : es[i][{c[1:0], 1'b1}];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      c           <= '0;
      packet_data <= '0;
      eh          <= '0;
      for (int i = 0; i < 4; i++) es[i] <= '0;
    end else if (!data_island_period) begin
      c           <= '0;
      packet_data <= '0;
    end else begin
      c           <= c + 5'd1;
      packet_data <= {odd_bits, even_bits, hdr_bit};
      if (c < 5'd24) eh <= eh_next;
      if (c < 5'd28) begin
        for (int i = 0; i < 4; i++) es[i] <= es_next[i];
      end
    end
  end

endmodule
